// File: rtl/jesd204_rx_cgs_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jesd204_rx_cgs_monitor_pkg
//  Description : Shared types, character codes and the per-character
//                code-group-synchronization step function for the
//                JESD204B receive CGS monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package jesd204_rx_cgs_monitor_pkg;

  // Lane synchronization states; the encoding is visible on o_cgs_state.
  typedef enum logic [1:0] {
    CGS_STATE_INIT  = 2'd0,
    CGS_STATE_CHECK = 2'd1,
    CGS_STATE_DATA  = 2'd2
  } cgs_state_e;

  // Control characters of interest.
  localparam logic [7:0] c_char_k28_0 = 8'h1C;
  localparam logic [7:0] c_char_k28_3 = 8'h7C;
  localparam logic [7:0] c_char_k28_5 = 8'hBC;
  localparam logic [7:0] c_char_k28_7 = 8'hFC;

  // Number of invalid characters in CHECK that drops the lane back to INIT,
  // and the number of consecutive valid characters that restores DATA.
  localparam logic [1:0] c_inv_limit = 2'd3;
  localparam logic [2:0] c_val_limit = 3'd4;

  // Synchronization state plus the counters that drive its transitions.
  // k_cnt is four bits because the K28.5 run length is capped at 15.
  typedef struct packed {
    cgs_state_e  state;
    logic [3:0]  k_cnt;
    logic [1:0]  inv_cnt;
    logic [2:0]  val_cnt;
  } cgs_sync_t;

  localparam cgs_sync_t c_sync_reset = '{
    state:   CGS_STATE_INIT,
    k_cnt:   4'd0,
    inv_cnt: 2'd0,
    val_cnt: 3'd0
  };

  // Advance the synchronization machine by exactly one character.
  function automatic cgs_sync_t cgs_step(
    input cgs_sync_t  cur,
    input logic       invalid,
    input logic       k285,
    input logic [3:0] k_count
  );
    cgs_sync_t nxt;
    nxt = cur;
    case (cur.state)
      CGS_STATE_INIT: begin
        if (k285) begin
          nxt.k_cnt = cur.k_cnt + 4'd1;
        end else begin
          nxt.k_cnt = 4'd0;
        end
        if (nxt.k_cnt == k_count) begin
          nxt.state = CGS_STATE_DATA;
          nxt.k_cnt = 4'd0;
        end
      end
      CGS_STATE_DATA: begin
        if (invalid) begin
          nxt.state   = CGS_STATE_CHECK;
          nxt.inv_cnt = 2'd1;
          nxt.val_cnt = 3'd0;
        end
      end
      CGS_STATE_CHECK: begin
        if (invalid) begin
          nxt.inv_cnt = cur.inv_cnt + 2'd1;
          nxt.val_cnt = 3'd0;
          if (nxt.inv_cnt == c_inv_limit) begin
            nxt.state = CGS_STATE_INIT;
            nxt.k_cnt = 4'd0;
          end
        end else begin
          nxt.val_cnt = cur.val_cnt + 3'd1;
          if (nxt.val_cnt == c_val_limit) begin
            nxt.state = CGS_STATE_DATA;
          end
        end
      end
      default: begin
        nxt = c_sync_reset;
      end
    endcase
    return nxt;
  endfunction

endpackage : jesd204_rx_cgs_monitor_pkg
`default_nettype wire

// File: rtl/jesd204_rx_cgs_char_classify.sv
`default_nettype none
// ============================================================================
//  Module      : jesd204_rx_cgs_char_classify
//  Description : Combinational classification of one decoded character into
//                invalid / K28.5 / unexpected-K flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module jesd204_rx_cgs_char_classify
  import jesd204_rx_cgs_monitor_pkg::*;
(
  input  logic [7:0] i_char,
  input  logic       i_charisk,
  input  logic       i_notintable,
  input  logic       i_disperr,
  output logic       o_invalid,
  output logic       o_k285,
  output logic       o_unexpected_k
);

  logic w_invalid;
  logic w_known_k;

  // A character with any decode error cannot be trusted as K or data.
  assign w_invalid = i_notintable | i_disperr;

  // K28.0, K28.3, K28.5 and K28.7 are the control characters a lane may carry.
  assign w_known_k = (i_char == c_char_k28_0) || (i_char == c_char_k28_3) ||
                     (i_char == c_char_k28_5) || (i_char == c_char_k28_7);

  assign o_invalid      = w_invalid;
  assign o_k285         = !w_invalid && i_charisk && (i_char == c_char_k28_5);
  assign o_unexpected_k = !w_invalid && i_charisk && !w_known_k;

endmodule : jesd204_rx_cgs_char_classify
`default_nettype wire

// File: rtl/jesd204_rx_cgs_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : jesd204_rx_cgs_monitor
//  Description : Per-lane JESD204B code-group-synchronization monitor.
//                Walks the INIT/CHECK/DATA machine across every character of
//                the cycle, drives lane ready and keeps saturating error
//                counters for status registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module jesd204_rx_cgs_monitor
  import jesd204_rx_cgs_monitor_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int K_COUNT         = 4,
  parameter int ERR_CNT_WIDTH   = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_en,
  input  logic [8*DATA_PATH_WIDTH-1:0] i_char,
  input  logic [DATA_PATH_WIDTH-1:0]   i_charisk,
  input  logic [DATA_PATH_WIDTH-1:0]   i_notintable,
  input  logic [DATA_PATH_WIDTH-1:0]   i_disperr,
  input  logic                         i_err_cnt_clear,
  output logic [1:0]                   o_cgs_state,
  output logic                         o_ready,
  output logic [ERR_CNT_WIDTH-1:0]     o_disperr_cnt,
  output logic [ERR_CNT_WIDTH-1:0]     o_notintable_cnt,
  output logic [ERR_CNT_WIDTH-1:0]     o_unexpected_k_cnt
);

  localparam int         c_pop_w   = $clog2(DATA_PATH_WIDTH + 1);
  localparam logic [3:0] c_k_count = 4'(K_COUNT);

  logic [DATA_PATH_WIDTH-1:0] w_invalid;
  logic [DATA_PATH_WIDTH-1:0] w_k285;
  logic [DATA_PATH_WIDTH-1:0] w_unexpected_k;
  cgs_sync_t                  w_sync_next;
  logic [c_pop_w-1:0]         w_disperr_pop;
  logic [c_pop_w-1:0]         w_notintable_pop;
  logic [c_pop_w-1:0]         w_unexpected_k_pop;

  cgs_sync_t                  r_sync;
  logic                       r_ready;
  logic [ERR_CNT_WIDTH-1:0]   r_disperr_cnt;
  logic [ERR_CNT_WIDTH-1:0]   r_notintable_cnt;
  logic [ERR_CNT_WIDTH-1:0]   r_unexpected_k_cnt;

  // Number of set bits in a per-character flag vector.
  function automatic logic [c_pop_w-1:0] popcount(
    input logic [DATA_PATH_WIDTH-1:0] v
  );
    logic [c_pop_w-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
      n = n + c_pop_w'(v[i]);
    end
    return n;
  endfunction

  // Add without wrapping: any carry out pins the counter at all-ones.
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_add(
    input logic [ERR_CNT_WIDTH-1:0] a,
    input logic [c_pop_w-1:0]       b
  );
    logic [ERR_CNT_WIDTH:0] s;
    s = {1'b0, a} + (ERR_CNT_WIDTH + 1)'(b);
    return s[ERR_CNT_WIDTH] ? {ERR_CNT_WIDTH{1'b1}} : s[ERR_CNT_WIDTH-1:0];
  endfunction

  // One classifier per character slot; slot 0 sits in the LSBs.
  generate
    for (genvar gi = 0; gi < DATA_PATH_WIDTH; gi++) begin : g_char
      jesd204_rx_cgs_char_classify u_classify (
        .i_char         (i_char[8*gi +: 8]),
        .i_charisk      (i_charisk[gi]),
        .i_notintable   (i_notintable[gi]),
        .i_disperr      (i_disperr[gi]),
        .o_invalid      (w_invalid[gi]),
        .o_k285         (w_k285[gi]),
        .o_unexpected_k (w_unexpected_k[gi])
      );
    end
  endgenerate

  // Ripple the sync machine through the characters in arrival order so each
  // one sees what its predecessor left behind.
  always_comb begin
    cgs_sync_t v;
    v = r_sync;
    for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
      v = cgs_step(v, w_invalid[i], w_k285[i], c_k_count);
    end
    w_sync_next = v;
  end

  assign w_disperr_pop      = popcount(i_disperr);
  assign w_notintable_pop   = popcount(i_notintable);
  assign w_unexpected_k_pop = popcount(w_unexpected_k);

  // Register the end-of-cycle sync state; disabling the lane forces INIT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync  <= c_sync_reset;
      r_ready <= 1'b0;
    end else if (!i_en) begin
      r_sync  <= c_sync_reset;
      r_ready <= 1'b0;
    end else begin
      r_sync  <= w_sync_next;
      r_ready <= (w_sync_next.state != CGS_STATE_INIT);
    end
  end

  // Saturating error counters; a clear discards the same cycle's errors.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_err_cnt_clear) begin
      r_disperr_cnt      <= '0;
      r_notintable_cnt   <= '0;
      r_unexpected_k_cnt <= '0;
    end else if (i_en) begin
      r_disperr_cnt      <= sat_add(r_disperr_cnt, w_disperr_pop);
      r_notintable_cnt   <= sat_add(r_notintable_cnt, w_notintable_pop);
      r_unexpected_k_cnt <= sat_add(r_unexpected_k_cnt, w_unexpected_k_pop);
    end
  end

  assign o_cgs_state        = r_sync.state;
  assign o_ready            = r_ready;
  assign o_disperr_cnt      = r_disperr_cnt;
  assign o_notintable_cnt   = r_notintable_cnt;
  assign o_unexpected_k_cnt = r_unexpected_k_cnt;

endmodule : jesd204_rx_cgs_monitor
`default_nettype wire

// File: tb/tb_jesd204_rx_cgs_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jesd204_rx_cgs_monitor
//  Description : Scoreboard bench for the JESD204B CGS monitor. A stream
//                model of the lane predicts every registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jesd204_rx_cgs_monitor;

  localparam int DPW   = 4;
  localparam int KCNT  = 4;
  localparam int ERR_W = 5;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  localparam int ST_INIT  = 0;
  localparam int ST_CHECK = 1;
  localparam int ST_DATA  = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 en = 1'b0;
  logic [8*DPW-1:0]     chr = '0;
  logic [DPW-1:0]       charisk = '0;
  logic [DPW-1:0]       notintable = '0;
  logic [DPW-1:0]       disperr = '0;
  logic                 err_cnt_clear = 1'b0;
  logic [1:0]           cgs_state;
  logic                 ready;
  logic [ERR_W-1:0]     disperr_cnt;
  logic [ERR_W-1:0]     notintable_cnt;
  logic [ERR_W-1:0]     unexpected_k_cnt;

  jesd204_rx_cgs_monitor #(
    .DATA_PATH_WIDTH (DPW),
    .K_COUNT         (KCNT),
    .ERR_CNT_WIDTH   (ERR_W)
  ) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_en               (en),
    .i_char             (chr),
    .i_charisk          (charisk),
    .i_notintable       (notintable),
    .i_disperr          (disperr),
    .i_err_cnt_clear    (err_cnt_clear),
    .o_cgs_state        (cgs_state),
    .o_ready            (ready),
    .o_disperr_cnt      (disperr_cnt),
    .o_notintable_cnt   (notintable_cnt),
    .o_unexpected_k_cnt (unexpected_k_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int state;
    int ready;
    int dis;
    int nit;
    int unk;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Lane model: current phase plus the run lengths the rules talk about.
  int m_phase = ST_INIT;
  int m_k_run = 0;
  int m_bad   = 0;
  int m_good  = 0;
  int m_dis   = 0;
  int m_nit   = 0;
  int m_unk   = 0;

  function automatic int sat(input int v);
    return (v > ERR_MAX) ? ERR_MAX : v;
  endfunction

  task automatic model_step(input bit rst, input bit e, input bit clr,
                            input logic [31:0] ch, input logic [3:0] k,
                            input logic [3:0] nit, input logic [3:0] de);
    int n_unk;
    if (rst) begin
      m_phase = ST_INIT; m_k_run = 0; m_bad = 0; m_good = 0;
      m_dis = 0; m_nit = 0; m_unk = 0;
      return;
    end
    if (!e) begin
      m_phase = ST_INIT; m_k_run = 0; m_bad = 0; m_good = 0;
      if (clr) begin m_dis = 0; m_nit = 0; m_unk = 0; end
      return;
    end
    n_unk = 0;
    for (int c = 0; c < DPW; c++) begin
      bit   bad;
      bit   is_k;
      byte unsigned v;
      v    = ch[8*c +: 8];
      is_k = k[c];
      bad  = nit[c] | de[c];
      if (!bad && is_k && !(v == 8'h1C || v == 8'h7C || v == 8'hBC || v == 8'hFC))
        n_unk++;
      if (m_phase == ST_INIT) begin
        m_k_run = (!bad && is_k && v == 8'hBC) ? m_k_run + 1 : 0;
        if (m_k_run == KCNT) begin m_phase = ST_DATA; m_k_run = 0; end
      end else if (m_phase == ST_DATA) begin
        if (bad) begin m_phase = ST_CHECK; m_bad = 1; m_good = 0; end
      end else begin
        if (bad) begin
          m_bad++; m_good = 0;
          if (m_bad == 3) begin m_phase = ST_INIT; m_k_run = 0; end
        end else begin
          m_good++;
          if (m_good == 4) m_phase = ST_DATA;
        end
      end
    end
    if (clr) begin
      m_dis = 0; m_nit = 0; m_unk = 0;
    end else begin
      m_dis = sat(m_dis + $countones(de));
      m_nit = sat(m_nit + $countones(nit));
      m_unk = sat(m_unk + n_unk);
    end
  endtask

  task automatic drive(input bit rst, input bit e, input bit clr,
                       input logic [31:0] ch, input logic [3:0] k,
                       input logic [3:0] nit, input logic [3:0] de);
    exp_t x;
    @(negedge clk);
    reset = rst; en = e; err_cnt_clear = clr;
    chr = ch; charisk = k; notintable = nit; disperr = de;
    model_step(rst, e, clr, ch, k, nit, de);
    x.state = m_phase;
    x.ready = (m_phase != ST_INIT) ? 1 : 0;
    x.dis   = m_dis;
    x.nit   = m_nit;
    x.unk   = m_unk;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // Monitor: every edge yields a registered result for the previous stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        chk("cgs_state", int'(cgs_state), x.state);
        chk("ready", int'(ready), x.ready);
        chk("disperr_cnt", int'(disperr_cnt), x.dis);
        chk("notintable_cnt", int'(notintable_cnt), x.nit);
        chk("unexpected_k_cnt", int'(unexpected_k_cnt), x.unk);
      end
    end
  end

  function automatic void rand_char(input bit all_k, output logic [7:0] v, output logic k);
    int r;
    r = $urandom_range(0, 99);
    if (all_k || r < 40) begin v = 8'hBC; k = 1'b1; end
    else if (r < 48) begin
      case ($urandom_range(0, 2))
        0: v = 8'h1C;
        1: v = 8'h7C;
        default: v = 8'hFC;
      endcase
      k = 1'b1;
    end
    else if (r < 55) begin v = 8'($urandom); k = 1'b1; end
    else begin v = 8'($urandom); k = 1'b0; end
  endfunction

  initial begin
    logic [31:0] ch;
    logic [3:0]  k, nit, de;
    bit          rst_r, en_r, clr_r, all_k;

    // Reset state
    drive(1, 0, 0, 32'h0, 4'h0, 4'h0, 4'h0);
    drive(1, 1, 0, 32'h0, 4'h0, 4'h0, 4'h0);
    // Four K28.5 in one cycle reach DATA
    drive(0, 1, 0, 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0);
    // Broken K28.5 run, then DATA reached mid-cycle
    drive(1, 1, 0, 32'h0, 4'h0, 4'h0, 4'h0);
    drive(0, 1, 0, 32'hBC00BCBC, 4'b1011, 4'h0, 4'h0);
    drive(0, 1, 0, 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0);
    // Single disparity error: CHECK, then back to DATA
    drive(0, 1, 0, 32'h33221100, 4'h0, 4'h0, 4'b0010);
    drive(0, 1, 0, 32'h77665544, 4'h0, 4'h0, 4'h0);
    // Three not-in-table characters drop to INIT; trailing K28.5 starts a run
    drive(0, 1, 0, 32'hBC000000, 4'b1000, 4'b0111, 4'h0);
    // Back to DATA, unexpected K on lane 2, then disable
    drive(0, 1, 0, 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0);
    drive(0, 1, 0, 32'h00F70000, 4'b0100, 4'h0, 4'h0);
    drive(0, 0, 0, 32'h00F70000, 4'b0100, 4'h0, 4'h0);
    drive(0, 1, 0, 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0);
    // Disparity errors on all lanes until saturation, then clear with errors
    for (int i = 0; i < 10; i++)
      drive(0, 1, 0, 32'h12345678, 4'h0, 4'h0, 4'hF);
    drive(0, 1, 1, 32'h12345678, 4'h0, 4'hF, 4'hF);
    drive(0, 1, 0, 32'h12345678, 4'h0, 4'h0, 4'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      all_k = ($urandom_range(0, 99) < 25);
      for (int c = 0; c < DPW; c++) begin
        logic [7:0] v;
        logic       kk;
        rand_char(all_k, v, kk);
        ch[8*c +: 8] = v;
        k[c] = kk;
        nit[c] = ($urandom_range(0, 99) < 4);
        de[c]  = ($urandom_range(0, 99) < 4);
      end
      rst_r = ($urandom_range(0, 999) < 5);
      en_r  = ($urandom_range(0, 99) >= 2);
      clr_r = ($urandom_range(0, 99) < 2);
      drive(rst_r, en_r, clr_r, ch, k, nit, de);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_jesd204_rx_cgs_monitor
`default_nettype wire
